mac_dot_sequencer: RTL and testbench

- Upstream controller for the team's pipelined signed DSP MAC slice; computes one dot product per job.
- Takes a job length over a start handshake, then accepts LEN operand pairs over a valid/ready stream and feeds them to the MAC as MAC_OP1/MAC_OP2/MAC_ACC_EN.
- Waits out the MAC pipeline, then returns the job result over a valid/ready result port.
- The MAC accumulator has no clear input, so each result is MAC_OUT at job end minus a baseline snapshot taken at job start (exact modulo 2^WIDTH_OUT).

---
 rtl/mac_dot_sequencer_if.sv | 53 +++++
 rtl/mac_dot_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_mac_dot_sequencer.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_dot_sequencer_if.sv
// Job/stream/result handshake bundle for mac_dot_sequencer.
// master: job source + operand producer + result consumer; slave: the sequencer.
interface mac_dot_sequencer_if #(
  parameter int WIDTH_OP1 = 18,
  parameter int WIDTH_OP2 = 18,
  parameter int WIDTH_OUT = 48,
  parameter int LEN_W     = 16
) ();

  logic                 START;
  logic [LEN_W-1:0]     LEN;
  logic                 CFG_READY;

  logic                 IN_VALID;
  logic                 IN_READY;
  logic [WIDTH_OP1-1:0] IN_A;
  logic [WIDTH_OP2-1:0] IN_B;

  logic                 RES_VALID;
  logic                 RES_READY;
  logic [WIDTH_OUT-1:0] RES_DATA;

  logic                 BUSY;

  modport master (
    output START,
    output LEN,
    input  CFG_READY,
    output IN_VALID,
    input  IN_READY,
    output IN_A,
    output IN_B,
    input  RES_VALID,
    output RES_READY,
    input  RES_DATA,
    input  BUSY
  );

  modport slave (
    input  START,
    input  LEN,
    output CFG_READY,
    input  IN_VALID,
    output IN_READY,
    input  IN_A,
    input  IN_B,
    output RES_VALID,
    input  RES_READY,
    output RES_DATA,
    output BUSY
  );

endinterface

// File: rtl/mac_dot_sequencer.sv
// Dot-product job sequencer in front of a pipelined signed MAC slice.
// Ports: CLK, RSTN (sync, active-low), bus (job/operand/result handshakes),
//   MAC_EN/MAC_ACC_EN/MAC_OP1/MAC_OP2 to the MAC, MAC_OUT from it.
module mac_dot_sequencer #(
  parameter int WIDTH_OP1 = 18,
  parameter int WIDTH_OP2 = 18,
  parameter int WIDTH_OUT = 48,
  parameter int LEN_W     = 16,
  parameter int MAC_LAT   = 3
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  mac_dot_sequencer_if.slave   bus,
  output logic                 MAC_EN,
  output logic                 MAC_ACC_EN,
  output logic [WIDTH_OP1-1:0] MAC_OP1,
  output logic [WIDTH_OP2-1:0] MAC_OP2,
  input  logic [WIDTH_OUT-1:0] MAC_OUT
);

  localparam int DRAIN_W = $clog2(MAC_LAT + 2);
  localparam logic [DRAIN_W-1:0] DRAIN_INIT =
    DRAIN_W'(MAC_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [LEN_W-1:0]     remaining;
  logic [DRAIN_W-1:0]   drain_cnt;
  logic [WIDTH_OUT-1:0] baseline;
  logic [WIDTH_OUT-1:0] res_data;
  logic                 res_valid;

  logic cfg_ready;
  logic in_ready;
  logic busy;

  logic start_fire;
  logic len_zero;
  logic in_fire;
  logic last_pair;
  logic drain_done;
  logic res_fire;

  assign start_fire = bus.START && cfg_ready;
  assign len_zero   = (bus.LEN == '0);
  assign in_fire    = bus.IN_VALID && in_ready;
  assign last_pair  = in_fire &&
                      (remaining == LEN_W'(1));
  assign drain_done = (state == S_DRAIN) &&
                      (drain_cnt == '0);
  assign res_fire   = (state == S_DONE) &&
                      res_valid && bus.RES_READY;

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (start_fire) begin
          state_nxt = len_zero ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (last_pair) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_done) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (res_fire) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = 1'b0;
    in_ready  = 1'b0;
    busy      = 1'b1;
    unique case (state)
      S_IDLE: begin
        cfg_ready = 1'b1;
        busy      = 1'b0;
      end
      S_RUN: begin
        in_ready = 1'b1;
      end
      S_DRAIN: begin
      end
      S_DONE: begin
      end
      default: begin
      end
    endcase
  end

  // Operand path: anything other than an accepted pair feeds the MAC
  // zeros with accumulate off, so bubbles and drain cycles add nothing.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      MAC_EN     <= 1'b0;
      MAC_ACC_EN <= 1'b0;
      MAC_OP1    <= '0;
      MAC_OP2    <= '0;
    end else begin
      MAC_EN     <= 1'b1;
      MAC_ACC_EN <= 1'b0;
      MAC_OP1    <= '0;
      MAC_OP2    <= '0;
      if (in_fire) begin
        MAC_ACC_EN <= 1'b1;
        MAC_OP1    <= bus.IN_A;
        MAC_OP2    <= bus.IN_B;
      end
    end
  end

  // The MAC cannot be cleared, so each job result is the accumulator
  // delta since acceptance; modular subtraction keeps it exact on wrap.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      remaining <= '0;
      drain_cnt <= '0;
      baseline  <= '0;
      res_data  <= '0;
      res_valid <= 1'b0;
    end else begin
      if (start_fire) begin
        baseline  <= MAC_OUT;
        remaining <= bus.LEN;
        if (len_zero) begin
          res_data  <= '0;
          res_valid <= 1'b1;
        end
      end
      if (in_fire) begin
        remaining <= remaining - LEN_W'(1);
        if (last_pair) begin
          drain_cnt <= DRAIN_INIT;
        end
      end
      if (state == S_DRAIN) begin
        if (drain_done) begin
          res_data  <= MAC_OUT - baseline;
          res_valid <= 1'b1;
        end else begin
          drain_cnt <= drain_cnt - DRAIN_W'(1);
        end
      end
      if (res_fire) begin
        res_valid <= 1'b0;
      end
    end
  end

  assign bus.CFG_READY = cfg_ready;
  assign bus.IN_READY  = in_ready;
  assign bus.BUSY      = busy;
  assign bus.RES_VALID = res_valid;
  assign bus.RES_DATA  = res_data;

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Scoreboard bench for mac_dot_sequencer with a behavioural MAC slice.
// Directed jobs push expected results; a forked monitor pops on handshake.
module tb_mac_dot_sequencer;

  localparam int W1  = 18;
  localparam int W2  = 18;
  localparam int WO  = 48;
  localparam int LW  = 16;
  localparam int LAT = 3;

  logic CLK = 1'b0;
  logic RSTN = 1'b0;

  logic          MAC_EN;
  logic          MAC_ACC_EN;
  logic [W1-1:0] MAC_OP1;
  logic [W2-1:0] MAC_OP2;
  logic [WO-1:0] MAC_OUT;

  mac_dot_sequencer_if #(
    .WIDTH_OP1(W1), .WIDTH_OP2(W2),
    .WIDTH_OUT(WO), .LEN_W(LW)
  ) bus ();

  mac_dot_sequencer #(
    .WIDTH_OP1(W1), .WIDTH_OP2(W2),
    .WIDTH_OUT(WO), .LEN_W(LW), .MAC_LAT(LAT)
  ) dut (
    .CLK(CLK),
    .RSTN(RSTN),
    .bus(bus),
    .MAC_EN(MAC_EN),
    .MAC_ACC_EN(MAC_ACC_EN),
    .MAC_OP1(MAC_OP1),
    .MAC_OP2(MAC_OP2),
    .MAC_OUT(MAC_OUT)
  );

  always #5 CLK = ~CLK;

  // MAC model: operands sampled at edge s reach the accumulator at s+LAT.
  logic signed [WO-1:0] a_ext, b_ext, prod;
  logic signed [WO-1:0] pipe_p [LAT];
  logic                 pipe_e [LAT];
  logic signed [WO-1:0] acc;

  assign a_ext = {{(WO-W1){MAC_OP1[W1-1]}}, MAC_OP1};
  assign b_ext = {{(WO-W2){MAC_OP2[W2-1]}}, MAC_OP2};
  assign prod  = a_ext * b_ext;
  assign MAC_OUT = acc;

  always @(posedge CLK) begin
    if (!RSTN) begin
      for (int i = 0; i < LAT; i++) begin
        pipe_p[i] <= '0;
        pipe_e[i] <= 1'b0;
      end
      acc <= '0;
    end else if (MAC_EN) begin
      pipe_p[0] <= prod;
      pipe_e[0] <= MAC_ACC_EN;
      for (int i = 1; i < LAT; i++) begin
        pipe_p[i] <= pipe_p[i-1];
        pipe_e[i] <= pipe_e[i-1];
      end
      if (pipe_e[LAT-1]) acc <= acc + pipe_p[LAT-1];
    end
  end

  int acc_cnt = 0;
  always @(negedge CLK) if (MAC_ACC_EN) acc_cnt = acc_cnt + 1;

  int checks = 0;
  int errors = 0;
  logic signed [WO-1:0] exp_q [$];

  task automatic chk(input string name, input longint act,
                     input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s act=%0d req=%0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_job(input int len);
    int n = 0;
    while (!bus.CFG_READY && n < 30) begin
      tick();
      n++;
    end
    if (!bus.CFG_READY) begin
      errors++;
      $display("FAIL start_timeout act=0 req=1");
    end
    bus.START = 1'b1;
    bus.LEN   = LW'(len);
    tick();
    bus.START = 1'b0;
    bus.LEN   = '0;
  endtask

  task automatic send(input int a, input int b, input logic v);
    bus.IN_VALID = v;
    bus.IN_A     = W1'(a);
    bus.IN_B     = W2'(b);
    tick();
    bus.IN_VALID = 1'b0;
    bus.IN_A     = '0;
    bus.IN_B     = '0;
  endtask

  task automatic wait_res(output int n);
    n = 0;
    while (!bus.RES_VALID && n < 50) begin
      tick();
      n++;
    end
    if (!bus.RES_VALID) begin
      errors++;
      $display("FAIL result_timeout act=0 req=1");
    end
  endtask

  int n;
  int acc_before;
  int va [6] = '{2, 999, 999, 4, 999, -6};
  int vb [6] = '{3, 999, 999, -5, 999, 7};
  logic vv [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    bus.START     = 1'b0;
    bus.LEN       = '0;
    bus.IN_VALID  = 1'b0;
    bus.IN_A      = '0;
    bus.IN_B      = '0;
    bus.RES_READY = 1'b1;

    fork
      forever begin
        @(negedge CLK);
        if (bus.RES_VALID && bus.RES_READY) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result act=%0d req=none",
                     $signed(bus.RES_DATA));
          end else begin
            chk("res_data", longint'($signed(bus.RES_DATA)),
                longint'(exp_q.pop_front()));
          end
        end
      end
    join_none

    // Reset state
    RSTN = 1'b0;
    tick();
    tick();
    chk("rst_cfg_ready", longint'(bus.CFG_READY), 1);
    chk("rst_busy", longint'(bus.BUSY), 0);
    chk("rst_in_ready", longint'(bus.IN_READY), 0);
    chk("rst_res_valid", longint'(bus.RES_VALID), 0);
    chk("rst_mac_en", longint'(MAC_EN), 0);
    chk("rst_acc_en", longint'(MAC_ACC_EN), 0);
    chk("rst_op1", longint'(MAC_OP1), 0);
    RSTN = 1'b1;
    tick();
    chk("mac_en_after_rst", longint'(MAC_EN), 1);

    // Job 1: 2*3 + 4*-5 + -6*7 = -56
    exp_q.push_back(-48'sd56);
    start_job(3);
    chk("run_in_ready", longint'(bus.IN_READY), 1);
    send(2, 3, 1'b1);
    send(4, -5, 1'b1);
    send(-6, 7, 1'b1);
    wait_res(n);
    chk("latency_job1", n, LAT + 2);

    // Back-to-back: 2 then 100
    exp_q.push_back(48'sd2);
    start_job(2);
    send(1, 1, 1'b1);
    send(1, 1, 1'b1);
    wait_res(n);
    exp_q.push_back(48'sd100);
    start_job(1);
    send(10, 10, 1'b1);
    wait_res(n);

    // Bubbles: valid 1,0,0,1,0,1 -> -56
    exp_q.push_back(-48'sd56);
    start_job(3);
    for (int i = 0; i < 6; i++) begin
      send(va[i], vb[i], vv[i]);
      chk($sformatf("acc_en_cyc%0d", i),
          longint'(MAC_ACC_EN), longint'(vv[i]));
    end
    wait_res(n);
    chk("latency_bubble", n, LAT + 2);

    // LEN = 0
    tick();
    acc_before = acc_cnt;
    exp_q.push_back(48'sd0);
    start_job(0);
    wait_res(n);
    chk("len0_fast", longint'(n <= 1), 1);
    tick();
    tick();
    chk("len0_no_acc", acc_cnt - acc_before, 0);

    // Hold result: 3*4 + 5*-6 = -18
    bus.RES_READY = 1'b0;
    exp_q.push_back(-48'sd18);
    start_job(2);
    send(3, 4, 1'b1);
    send(5, -6, 1'b1);
    wait_res(n);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        bus.START = 1'b1;
        bus.LEN   = LW'(7);
      end
      tick();
      bus.START = 1'b0;
      bus.LEN   = '0;
      chk($sformatf("hold_valid%0d", i),
          longint'(bus.RES_VALID), 1);
      chk($sformatf("hold_data%0d", i),
          longint'($signed(bus.RES_DATA)), -18);
    end
    bus.RES_READY = 1'b1;
    tick();
    chk("post_hold_cfg_ready", longint'(bus.CFG_READY), 1);
    tick();
    chk("start_not_queued", longint'(bus.BUSY), 0);

    // Reset mid-RUN, then (-131072)^2 = 2^34
    start_job(4);
    send(100, 100, 1'b1);
    send(5, 5, 1'b1);
    RSTN = 1'b0;
    tick();
    chk("midrst_cfg_ready", longint'(bus.CFG_READY), 1);
    chk("midrst_res_valid", longint'(bus.RES_VALID), 0);
    RSTN = 1'b1;
    tick();
    tick();
    tick();
    tick();
    tick();
    chk("midrst_no_result", longint'(bus.RES_VALID), 0);
    exp_q.push_back(48'sd17179869184);
    start_job(1);
    send(-131072, -131072, 1'b1);
    wait_res(n);
    chk("latency_big", n, LAT + 2);
    tick();
    tick();

    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
